// File: rtl/apb_cmd_master.sv
// Command-queued APB master: host commands are buffered in a small FIFO and
// issued as IDLE->SETUP->ACCESS transfers, with one response per command.
module apb_cmd_master #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic                     PWRITE,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PREADY,
  output logic                     rsp_valid,
  output logic                     rsp_write,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = ADDR_W + DATA_W + 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [7:0]  TO_LIM   = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t         state;
  logic [CW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           pending;
  logic [7:0]     wait_cnt;

  logic           push;
  logic           pop;
  logic           fifo_has;
  logic           done;
  logic           timeout;
  logic [CW-1:0]  in_cmd;
  logic [CW-1:0]  head;

  always_comb begin
    in_cmd    = {cmd_write, cmd_addr, cmd_wdata};
    cmd_ready = (count != FULL_LVL);
    push      = cmd_valid && cmd_ready;
    // An empty FIFO popped on the same edge as a push hands the incoming command straight through
    head      = (count == '0) ? in_cmd : mem[rd_ptr];
    timeout   = !PREADY && ((wait_cnt + 8'd1) == TO_LIM);
    done      = (state == ACCESS) && (PREADY || timeout);
    fifo_has  = (count != '0) || push;
    pop       = ((state == IDLE) && pending) || (done && fifo_has);
  end

  assign fifo_level = count;

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  // pending lags count by one cycle, giving IDLE its one-cycle look before SETUP
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      pending <= (count != '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid <= 1'b1;
            rsp_write <= PWRITE;
            rsp_err   <= timeout;
            rsp_rdata <= (PWRITE || timeout) ? '0 : PRDATA;
            if (!fifo_has) begin
              state   <= IDLE;
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // Loading the next command overrides the per-state updates above
      if (pop) begin
        state                   <= SETUP;
        PSEL                    <= 1'b1;
        PENABLE                 <= 1'b0;
        {PWRITE, PADDR, PWDATA} <= head;
        wait_cnt                <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: scoreboard of expected APB setups and responses,
// a table of single transfers, and hand-written multi-cycle sequences.
module tb_apb_cmd_master;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [2:0] fifo_level;
  logic       PSEL, PENABLE, PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY;
  logic       rsp_valid, rsp_write, rsp_err;
  logic [7:0] rsp_rdata;

  apb_cmd_master #(.ADDR_W(4), .DATA_W(8), .DEPTH(4), .TIMEOUT(15)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .fifo_level(fifo_level),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {logic w; logic [3:0] a; logic [7:0] d;} apb_t;
  typedef struct packed {logic w; logic [7:0] rd; logic e;} rsp_t;
  typedef struct {
    logic w; logic [3:0] a; logic [7:0] d; logic [7:0] prd;
    int unsigned wn; logic [7:0] exp_rd; logic exp_err; int unsigned exp_acc;
  } vec_t;

  apb_t        apb_q[$];
  rsp_t        rsp_q[$];
  vec_t        vecs[7];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned wait_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Slave model: PREADY low for wait_n ACCESS cycles, then high
  initial begin
    int unsigned k = 0;
    PREADY = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        PREADY = (k >= wait_n);
        k++;
      end else begin
        PREADY = 1'b0;
        k = 0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    apb_t ea;
    rsp_t er;
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        if (PSEL && !PENABLE) begin
          if (apb_q.size() == 0) chk("setup_unexpected", 32'd1, 32'd0);
          else begin
            ea = apb_q.pop_front();
            chk("setup_cmd", {19'd0, PWRITE, PADDR, PWDATA}, {19'd0, ea});
          end
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
          else begin
            er = rsp_q.pop_front();
            chk("rsp", {22'd0, rsp_write, rsp_rdata, rsp_err}, {22'd0, er});
          end
        end
      end
    end
  end

  task automatic push_cmd(input logic w, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] erd, input logic ee, output int unsigned waited);
    waited = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && waited < 200) begin
      @(negedge PCLK);
      waited++;
    end
    if (!cmd_ready) chk("push_timeout", 32'd1, 32'd0);
    @(posedge PCLK);
    apb_q.push_back({w, a, d});
    rsp_q.push_back({w, erd, ee});
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while ((apb_q.size() != 0 || rsp_q.size() != 0 || PSEL) && n < 400);
    if (n >= 400) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_access();
    int unsigned n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(PSEL && PENABLE) && n < 50);
    if (n >= 50) chk("access_timeout", 32'd1, 32'd0);
  endtask

  task automatic count_psel(output int unsigned hi);
    int unsigned n = 0;
    bit seen = 0;
    hi = 0;
    while (n < 100) begin
      @(negedge PCLK);
      n++;
      if (PSEL) begin hi++; seen = 1; end
      else if (seen) break;
    end
  endtask

  initial begin
    int unsigned w, hi, acc, n, bad;
    vecs[0] = '{1'b1, 4'h0, 8'h03, 8'h55, 0,  8'h00, 1'b0, 1};
    vecs[1] = '{1'b0, 4'h2, 8'h00, 8'h3C, 0,  8'h3C, 1'b0, 1};
    vecs[2] = '{1'b0, 4'h5, 8'h00, 8'hA5, 3,  8'hA5, 1'b0, 4};
    vecs[3] = '{1'b1, 4'hF, 8'h81, 8'h12, 2,  8'h00, 1'b0, 3};
    vecs[4] = '{1'b0, 4'h7, 8'h00, 8'h66, 15, 8'h00, 1'b1, 15};
    vecs[5] = '{1'b1, 4'h1, 8'hEE, 8'h44, 20, 8'h00, 1'b1, 15};
    vecs[6] = '{1'b0, 4'h3, 8'h00, 8'h99, 14, 8'h99, 1'b0, 15};

    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; PRDATA = '0;
    repeat (2) @(negedge PCLK);
    chk("rst_psel_pen", {30'd0, PSEL, PENABLE}, 32'd0);
    chk("rst_paddr_pwdata_pwrite", {19'd0, PWRITE, PADDR, PWDATA}, 32'd0);
    chk("rst_rsp", {22'd0, rsp_valid, rsp_write, rsp_err, rsp_rdata}, 32'd0);
    chk("rst_fifo", {28'd0, cmd_ready, fifo_level}, {28'd0, 1'b1, 3'd0});
    PRESETn = 1'b1;

    // Single write latency: push at E0, SETUP after E2, ACCESS after E3, rsp after E4
    wait_n = 0;
    push_cmd(1'b1, 4'h0, 8'h03, 8'h00, 1'b0, w);
    @(negedge PCLK); chk("lat_e0_psel", {31'd0, PSEL}, 32'd0);
    @(negedge PCLK); chk("lat_e1_psel", {31'd0, PSEL}, 32'd0);
    @(negedge PCLK); chk("lat_e2_setup", {17'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {17'd0, 3'b101, 4'h0, 8'h03});
    @(negedge PCLK); chk("lat_e3_access", {30'd0, PSEL, PENABLE}, 32'd3);
    @(negedge PCLK); chk("lat_e4_rsp", {30'd0, rsp_valid, PSEL}, 32'd2);
    wait_idle();

    foreach (vecs[i]) begin
      wait_n = vecs[i].wn;
      PRDATA = vecs[i].prd;
      push_cmd(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, vecs[i].exp_err, w);
      acc = 0; n = 0;
      while (n < 200) begin
        @(negedge PCLK);
        n++;
        if (rsp_valid) break;
        if (PSEL && PENABLE) acc++;
      end
      chk($sformatf("vec%0d_access_cycles", i), acc, vecs[i].exp_acc);
      wait_idle();
    end

    // Back-to-back: three pushes on consecutive edges, PSEL high for 6 cycles
    wait_n = 0; PRDATA = 8'h19;
    push_cmd(1'b1, 4'h1, 8'h02, 8'h00, 1'b0, w);
    push_cmd(1'b1, 4'h0, 8'hFF, 8'h00, 1'b0, w);
    push_cmd(1'b0, 4'h2, 8'h00, 8'h19, 1'b0, w);
    count_psel(hi);
    chk("b2b_psel_cycles", hi, 32'd6);
    wait_idle();

    // Push on the completion edge of a lone transfer: next SETUP follows with no IDLE gap
    PRDATA = 8'h5A;
    push_cmd(1'b0, 4'h6, 8'h00, 8'h5A, 1'b0, w);
    fork
      begin repeat (3) @(negedge PCLK); push_cmd(1'b1, 4'h8, 8'hC3, 8'h00, 1'b0, w); end
      count_psel(hi);
    join
    chk("same_edge_push_psel_cycles", hi, 32'd4);
    wait_idle();

    // Full FIFO behind a stalled transfer; the 5th push waits for a pop
    wait_n = 40; PRDATA = 8'h77;
    push_cmd(1'b0, 4'h0, 8'h00, 8'h00, 1'b1, w);
    wait_access();
    for (int unsigned j = 0; j < 4; j++) push_cmd(1'b1, 4'(j + 1), 8'(j + 8'h40), 8'h00, 1'b1, w);
    @(negedge PCLK);
    chk("full_level_ready", {28'd0, cmd_ready, fifo_level}, {28'd0, 1'b0, 3'd4});
    push_cmd(1'b0, 4'hA, 8'h00, 8'h00, 1'b1, w);
    chk("full_push_waited", {31'd0, w > 0}, 32'd1);
    @(negedge PCLK);
    chk("full_level_after_pop_push", {29'd0, fifo_level}, 32'd4);
    wait_idle();

    // Reset mid-ACCESS with two commands queued
    wait_n = 40;
    push_cmd(1'b1, 4'h2, 8'h11, 8'h00, 1'b1, w);
    wait_access();
    push_cmd(1'b1, 4'h3, 8'h22, 8'h00, 1'b1, w);
    push_cmd(1'b0, 4'h4, 8'h00, 8'h00, 1'b1, w);
    @(negedge PCLK);
    chk("pre_reset_level", {29'd0, fifo_level}, 32'd2);
    #2 PRESETn = 1'b0;
    apb_q.delete(); rsp_q.delete();
    #1;
    chk("async_rst_apb", {30'd0, PSEL, PENABLE}, 32'd0);
    chk("async_rst_fifo", {27'd0, rsp_valid, cmd_ready, fifo_level}, {27'd0, 1'b0, 1'b1, 3'd0});
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1; wait_n = 0;
    bad = 0;
    repeat (30) begin
      @(negedge PCLK);
      if (rsp_valid || PSEL) bad++;
    end
    chk("no_activity_after_reset", bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
